aes_encrypt_iter: RTL and testbench
===================================

// Module: aes_encrypt_iter
// PURPOSE
//  Iterative AES block cipher core (FIPS-197). Performs one cipher round per clock.
//  Consumes the flat round-key schedule produced by KeyExpansion and emits one ciphertext block.
//  Sits between KeyExpansion and the aes top level. NK/NR select AES-128/192/256.
//  Valid/ready handshakes on both the input and output sides.
// PARAMETERS
//  NK  4   key length in 32-bit words (4/6/8)
//  NR  10  number of rounds (10/12/14); must match the KeyExpansion instance
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  key_sched  in   128*(NR+1)     [0:128*(NR+1)-1] round keys; bits [128r+:128] = round key r
//  in_valid   in   1              in_data is valid
//  in_ready   out  1              core can accept a block
//  in_data    in   128            [0:127] plaintext; byte 0 = [0:7]; column-major state as FIPS-197
//  out_valid  out  1              out_data holds a ciphertext block
//  out_ready  in   1              consumer accepts out_data
//  out_data   out  128            [0:127] ciphertext, same byte order as in_data
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0; out_data=0; round counter=0. in_ready=0 during the reset cycle.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: in_ready=1. On in_valid: state <= in_data ^ rk0, rnd <= 1, go to RUN.
//    - RUN: in_ready=0; each cycle state <= round(state, rk[rnd]), rnd++.
//      Rounds 1..NR-1 apply SubBytes, ShiftRows, MixColumns, then AddRoundKey.
//      Round NR omits MixColumns. When rnd==NR, go to DONE.
//    - DONE: out_valid=1; out_data is stable until out_valid && out_ready.
//  - Latency: the accept edge is T; out_valid rises after edge T+NR (10/12/14 cycles).
//  - Back-to-back: in_ready = IDLE | (DONE & out_ready).
//    If the output is consumed and a new input arrives in the same cycle, load the new block and go to RUN.
//    out_valid drops the next cycle.
//  - DONE with out_ready=0: hold indefinitely; in_ready=0 and inputs are ignored.
//  - in_valid while in RUN: ignored, with no side effect.
//  - key_sched is not registered. It must stay stable from the accept edge until the output handshake.
//  - Round counter width is $clog2(NR+1). There is no wrap: the counter resets to 1 on each load.
//  - rst asserted mid-RUN or in DONE: abort. The next cycle shows the reset values and the block is lost.
//  - MixColumns uses GF(2^8) xtime with the reduction polynomial 0x11b.
// STRUCTURE
//  - aes_pkg holds:
//    - the sbox function (256-entry case)
//    - the xtime function and mix_column (32-bit) function
//    - the typedef for the FSM state and constants NB=4 and BLK=128
//    KeyExpansion switches to the aes_pkg sbox as well.
//  - Sub-module aes_round (combinational): in=state, rk, last flag; out=next state.
//    It instantiates 16 sbox lookups, ShiftRows wiring, 4 mix_column instances and the XOR.
//  - Top level: FSM, round counter, state register, output register, rk mux (key_sched[128*rnd+:128]).
// TESTING
//  1. AES-128, FIPS-197 App. B:
//     key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
//     Expect 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after accept.
//  2. AES-192 (NK=6, NR=12): key 000102..1617, pt 00112233445566778899aabbccddeeff.
//     Expect dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
//  3. AES-256 (NK=8, NR=14): key 000102..1e1f, same pt.
//     Expect 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
//  4. Backpressure: hold out_ready=0 for 20 cycles after DONE.
//     out_data is stable, in_ready=0, and a pulse on in_valid is ignored.
//     Raising out_ready completes exactly one transfer.
//  5. Back-to-back: keep in_valid=1 and out_ready=1 with two blocks.
//     The second block loads in the same cycle as the first is consumed, giving one output every 11 cycles (AES-128).
//  6. Reset at RUN round 5: the next cycle has out_valid=0, out_data=0 and in_ready=1.
//     Re-running vector 1 then gives the correct ciphertext.
//  All cases: key_sched is driven from a KeyExpansion instance with the matching NK/NR.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block constants, FSM state type and the GF(2^8)
// byte/column helpers used by the round datapath and the key schedule.
package aes_pkg;

  localparam int NB  = 4;
  localparam int BLK = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLK-1:0] state_i,
  input  logic [BLK-1:0] rk_i,
  input  logic           last_i,
  output logic [BLK-1:0] state_o
);

  logic [BLK-1:0] sub_bytes;
  logic [BLK-1:0] shift_rows;
  logic [BLK-1:0] mix_cols;

  for (genvar k = 0; k < 16; k++) begin : g_sub
    assign sub_bytes[BLK-1-8*k -: 8] = sbox(state_i[BLK-1-8*k -: 8]);
  end

  // Row r of column c takes the byte from column (c + r) mod 4.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_rows[BLK-1-32*c-8*r -: 8] = sub_bytes[BLK-1-32*((c+r)%NB)-8*r -: 8];
    end
    assign mix_cols[BLK-1-32*c -: 32] = mix_column(shift_rows[BLK-1-32*c -: 32]);
  end

  assign state_o = (last_i ? shift_rows : mix_cols) ^ rk_i;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock over an externally supplied
// round-key schedule, with valid/ready handshakes on input and output.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLK*(NR+1)-1:0]   key_sched,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLK-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK-1:0]          out_data
);

  localparam int KSW = BLK * (NR + 1);
  localparam int RW  = $clog2(NR + 1);

  if (NR != NK + 6) begin : g_bad_cfg
    $error("aes_encrypt_iter: NR must equal NK + 6");
  end

  aes_fsm_e        fsm_q;
  logic [RW-1:0]   rnd_q;
  logic [BLK-1:0]  state_q;
  logic [BLK-1:0]  out_data_q;
  logic            out_valid_q;

  logic [BLK-1:0]  rk_arr [0:NR];
  logic [BLK-1:0]  round_out;
  logic            last_rnd;
  logic            accept;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk_arr[r] = key_sched[KSW-1-BLK*r -: BLK];
  end

  assign last_rnd = (rnd_q == RW'(NR));
  assign in_ready = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_arr[rnd_q]),
    .last_i  (last_rnd),
    .state_o (round_out)
  );

  // A load (from IDLE, or from DONE while the result is taken) overrides the state case.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state_q     <= in_data ^ rk_arr[0];
      rnd_q       <= RW'(1);
      fsm_q       <= RUN;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: fsm_q <= IDLE;
        RUN: begin
          state_q <= round_out;
          if (last_rnd) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= round_out;
          end else begin
            rnd_q <= rnd_q + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: AES-128/192/256 instances fed from a
// bench-side key expansion, checked against FIPS-197 / SP800-38A vectors.
module tb_aes_encrypt_iter;
  import aes_pkg::*;

  typedef struct {
    int           inst;
    logic [127:0] data;
    int           acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv   [3];
  logic [127:0] idat [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] od   [3];
  logic [1407:0] ks128;
  logic [1663:0] ks192;
  logic [1919:0] ks256;

  sb_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  xfers [3] = '{0, 0, 0};
  int  rise_cyc [3] = '{0, 0, 0};
  int  prev_rise [3] = '{0, 0, 0};
  logic ov_prev [3];
  int  nr_tab [3] = '{10, 12, 14};

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encrypt_iter #(.NK(4), .NR(10)) u_dut128 (
    .clk(clk), .rst(rst), .key_sched(ks128),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));

  aes_encrypt_iter #(.NK(6), .NR(12)) u_dut192 (
    .clk(clk), .rst(rst), .key_sched(ks192),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));

  aes_encrypt_iter #(.NK(8), .NR(14)) u_dut256 (
    .clk(clk), .rst(rst), .key_sched(ks256),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 KeyExpansion; key is MSB-aligned, schedule word i at [1919-32i -: 32].
  function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      ks[1919-32*i -: 32] = w[i];
    end
    return ks;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input int i, input logic [127:0] pt, input logic [127:0] ct);
    int n;
    @(negedge clk);
    iv[i]   = 1'b1;
    idat[i] = pt;
    n = 0;
    #1;
    while (ir[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n < 100) sb.push_back('{i, ct, cyc + 1});
    chk("accept_in_time", 128'(n < 100), 128'd1);
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while ((sb.size() != 0 || ov[i] !== 1'b0) && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_in_time", 128'(n < 100), 128'd1);
  endtask

  // Monitor: pop the scoreboard on each rising out_valid and count handshakes.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (!rst && ov[i] === 1'b1 && ov_prev[i] !== 1'b1) begin
          prev_rise[i] = rise_cyc[i];
          rise_cyc[i]  = cyc;
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: inst %0d got %0h with nothing pending", i, od[i]);
          end else begin
            e = sb.pop_front();
            chk("sb_inst", 128'(i), 128'(e.inst));
            chk("ciphertext", od[i], e.data);
            chk("latency", 128'(cyc - e.acc), 128'(nr_tab[i]));
          end
        end
        if (!rst && ov[i] === 1'b1 && ordy[i] === 1'b1) xfers[i]++;
        ov_prev[i] = ov[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    logic [1919:0] full;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      idat[i] = '0;
      ordy[i] = 1'b1;
    end
    full  = key_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    ks128 = full[1919 -: 1408];
    full  = key_expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    ks192 = full[1919 -: 1664];
    full  = key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    ks256 = full;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 128'(ov[i]), 128'd0);
      chk("rst_out_data", od[i], 128'd0);
      chk("rst_in_ready", 128'(ir[i]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("idle_in_ready", 128'(ir[i]), 128'd1);

    // AES-128 / 192 / 256 known-answer vectors
    send(0, PT1, CT1);
    wait_drain(0);
    send(1, PT3, CT192);
    wait_drain(1);
    send(2, PT3, CT256);
    wait_drain(2);

    // Backpressure: result held for 20 cycles, stray in_valid ignored
    ordy[0] = 1'b0;
    send(0, PT1, CT1);
    for (int n = 0; n < 40 && ov[0] !== 1'b1; n++) begin
      @(negedge clk);
      #1;
    end
    x0 = xfers[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      iv[0]   = (k == 5);
      idat[0] = PT2;
      #1;
      chk("bp_hold_data", od[0], CT1);
      chk("bp_hold_valid", 128'(ov[0]), 128'd1);
      chk("bp_in_ready", 128'(ir[0]), 128'd0);
    end
    @(negedge clk);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("bp_one_transfer", 128'(xfers[0] - x0), 128'd1);
    chk("bp_after_valid", 128'(ov[0]), 128'd0);
    chk("bp_after_in_ready", 128'(ir[0]), 128'd1);
    chk("bp_nothing_pending", 128'(sb.size()), 128'd0);

    // Back-to-back: second block loads as the first is consumed
    send(0, PT1, CT1);
    send(0, PT2, CT2);
    wait_drain(0);
    chk("b2b_period", 128'(rise_cyc[0] - prev_rise[0]), 128'd11);

    // Abort in round 5, then rerun vector 1
    send(0, PT1, CT1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_out_valid", 128'(ov[0]), 128'd0);
    chk("abort_out_data", od[0], 128'd0);
    chk("abort_in_ready", 128'(ir[0]), 128'd1);
    chk("abort_pending", 128'(sb.size()), 128'd1);
    sb.delete();
    send(0, PT1, CT1);
    wait_drain(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
